// File: rtl/chacha20_stream.sv
// chacha20_stream: ChaCha20 keystream controller and 32-bit stream XOR stage.
// Define CHACHA_PREFETCH_EN to compute the next block while the current one streams.
module chacha20_stream #(
  parameter int WAIT_MIN = 12,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [255:0] key,
  input  logic [95:0] nonce,
  input  logic [31:0] ctr_init,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        ctr_wrap,
  output logic        blk_start,
  output logic [31:0] blk_state_in [0:15],
  input  logic        blk_done,
  input  logic [31:0] blk_state_out [0:15],
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT_KS, STREAM} state_t;
  state_t state, state_n;
  logic [255:0] key_r;
  logic [95:0] nonce_r;
  logic [31:0] ctr;
  logic [CNT_W-1:0] wcnt;
  logic [31:0] ks [0:15];
  logic [3:0] idx;
  logic done_ok, cap, acc, start, wait_clr, ctr_inc, ks_load;
  assign done_ok = blk_done && wcnt == CNT_W'(WAIT_MIN);
  assign cap = state == WAIT_KS && done_ok;
  assign acc = in_valid && in_ready;
  assign start = state == IDLE && load;
  assign busy = state != IDLE;
`ifdef CHACHA_PREFETCH_EN
  localparam bit PF = 1'b1;
  typedef enum logic [1:0] {PF_IDLE, PF_START, PF_WAIT, PF_DONE} pf_t;
  pf_t pf, pf_n;
  logic [31:0] ks2 [0:15];
  logic empty, pf_cap, roll, swap;
  assign pf_cap = pf == PF_WAIT && done_ok;
  assign roll = acc && idx == 4'd15 && !in_last;
  assign swap = roll && pf == PF_DONE;
  assign in_ready = state == STREAM && !empty && (!out_valid || out_ready);
  assign blk_start = state == START || pf == PF_START;
  assign wait_clr = blk_start;
  assign ctr_inc = cap || pf_cap;
  // a prefetch landing while the current block is exhausted goes straight to ks
  assign ks_load = cap || (pf_cap && (empty || roll));
  always_comb begin
    pf_n = pf;
    case (pf)
      PF_IDLE: pf_n = cap ? PF_START : PF_IDLE;
      PF_START: pf_n = PF_WAIT;
      PF_WAIT: pf_n = pf_cap ? ((empty || roll) ? PF_START : PF_DONE) : PF_WAIT;
      PF_DONE: pf_n = swap ? PF_START : PF_DONE;
    endcase
    if (acc && in_last) pf_n = PF_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pf <= PF_IDLE;
      empty <= 1'b0;
      ks2 <= '{default: '0};
    end else begin
      pf <= pf_n;
      empty <= (empty && !pf_cap) || (roll && pf != PF_DONE && !pf_cap);
      if (pf_cap && !empty && !roll) ks2 <= blk_state_out;
    end
`else
  localparam bit PF = 1'b0;
  assign in_ready = state == STREAM && (!out_valid || out_ready);
  assign blk_start = state == START;
  assign wait_clr = blk_start;
  assign ctr_inc = cap;
  assign ks_load = cap;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = load ? START : IDLE;
      START: state_n = WAIT_KS;
      WAIT_KS: state_n = cap ? STREAM : WAIT_KS;
      STREAM: state_n = (acc && in_last) ? IDLE : (acc && idx == 4'd15 && !PF) ? START : STREAM;
    endcase
  end
  always_comb begin
    blk_state_in[0] = 32'h61707865;
    blk_state_in[1] = 32'h3320646e;
    blk_state_in[2] = 32'h79622d32;
    blk_state_in[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) blk_state_in[4+i] = key_r[32*i+:32];
    blk_state_in[12] = ctr;
    for (int i = 0; i < 3; i++) blk_state_in[13+i] = nonce_r[32*i+:32];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ks <= '{default: '0};
    else if (ks_load) ks <= blk_state_out;
`ifdef CHACHA_PREFETCH_EN
    else if (swap) ks <= ks2;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      key_r <= '0;
      nonce_r <= '0;
      ctr <= '0;
      ctr_wrap <= 1'b0;
      wcnt <= '0;
      idx <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        key_r <= key;
        nonce_r <= nonce;
      end
      ctr <= start ? ctr_init : ctr_inc ? ctr + 32'd1 : ctr;
      ctr_wrap <= start ? 1'b0 : (ctr_inc && ctr == '1) ? 1'b1 : ctr_wrap;
      wcnt <= wait_clr ? '0 : (wcnt == CNT_W'(WAIT_MIN)) ? wcnt : wcnt + 1'b1;
      idx <= cap ? 4'd0 : acc ? idx + 4'd1 : idx;
      if (acc) begin
        out_data <= in_data ^ ks[idx];
        out_last <= in_last;
      end
      out_valid <= acc || (out_valid && !out_ready);
    end
endmodule

// File: tb/tb_chacha20_stream.sv
// tb_chacha20_stream: randomized bench with a behavioural ChaCha20 core and keystream model.
module tb_chacha20_stream;
  localparam int WAIT_MIN = 12;
`ifdef CHACHA_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  logic clk = 0, rst_n = 0, load = 0;
  logic [255:0] key = '0;
  logic [95:0] nonce = '0;
  logic [31:0] ctr_init = '0, in_data = '0, out_data;
  logic in_valid = 0, in_ready, in_last = 0, out_valid, out_ready = 1, out_last;
  logic ctr_wrap, blk_start, busy, blk_done = 0;
  logic [31:0] blk_state_in [0:15];
  logic [31:0] blk_state_out [0:15] = '{default: 32'h0};
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  chacha20_stream #(.WAIT_MIN(WAIT_MIN), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .key(key), .nonce(nonce), .ctr_init(ctr_init),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .ctr_wrap(ctr_wrap), .blk_start(blk_start), .blk_state_in(blk_state_in),
    .blk_done(blk_done), .blk_state_out(blk_state_out), .busy(busy));

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [127:0] qr(input logic [127:0] v);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = v;
    a += b; d = rotl(d ^ a, 16); c += d; b = rotl(b ^ c, 12);
    a += b; d = rotl(d ^ a, 8);  c += d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction
  function automatic logic [31:0] chacha_word(input logic [511:0] st, input int w);
    logic [31:0] x [16];
    for (int i = 0; i < 16; i++) x[i] = st[32*i+:32];
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++)
        {x[i], x[4+i], x[8+i], x[12+i]} = qr({x[i], x[4+i], x[8+i], x[12+i]});
      for (int i = 0; i < 4; i++)
        {x[i], x[4+(i+1)%4], x[8+(i+2)%4], x[12+(i+3)%4]} =
          qr({x[i], x[4+(i+1)%4], x[8+(i+2)%4], x[12+(i+3)%4]});
    end
    return x[w] + st[32*w+:32];
  endfunction
  function automatic logic [31:0] exp_ks(input logic [255:0] k, input logic [95:0] n,
                                         input logic [31:0] c, input int j);
    logic [31:0] bc;
    bc = c + 32'(j / 16);
    return chacha_word({n, bc, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865}, j % 16);
  endfunction

  // core stand-in: garbage until its latency elapses, so an early capture corrupts data
  int cyc = 0, core_cnt = 0;
  bit early = 0;
  logic [511:0] core_st;
  logic [31:0] start_ctr [$];
  int start_cyc [$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (blk_start) begin
      for (int i = 0; i < 16; i++) begin
        core_st[32*i+:32] <= blk_state_in[i];
        blk_state_out[i] <= 32'hdead0000 | 32'(i);
      end
      blk_done <= early;
      core_cnt <= early ? WAIT_MIN : int'($urandom_range(1, WAIT_MIN));
      start_ctr.push_back(blk_state_in[12]);
      start_cyc.push_back(cyc);
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        for (int i = 0; i < 16; i++) blk_state_out[i] <= chacha_word(core_st, i);
        blk_done <= 1'b1;
      end
    end

  logic [31:0] got_d [$];
  bit got_l [$];
  int got_cyc [$];
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      got_cyc.push_back(cyc);
    end

  logic [31:0] msg [64];
  int waits [64];
  bit timed_out, held, hold_bad, hold_inrdy;

  task automatic do_load(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    @(posedge clk); #1;
    key = k; nonce = n; ctr_init = c; load = 1;
    @(posedge clk); #1;
    load = 0;
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    nonce = {$urandom, $urandom, $urandom};
    ctr_init = $urandom;
  endtask

  task automatic run_msg(input int n, input bit rnd, input int hold_at, input int abort_at);
    int i, budget;
    bit acc;
    logic [31:0] d;
    logic l;
    i = 0; budget = 0;
    timed_out = 0; held = 0; hold_bad = 0; hold_inrdy = 0;
    for (int j = 0; j < 64; j++) waits[j] = 0;
    in_valid = 1; in_data = msg[0]; in_last = (n == 1);
    while (i < n && i != abort_at) begin
      if (i == hold_at && !held && out_valid) begin
        held = 1; out_ready = 0; d = out_data; l = out_last;
        repeat (5) begin
          @(negedge clk);
          if (out_data !== d || out_last !== l) hold_bad = 1;
          if (in_ready) hold_inrdy = 1;
        end
        @(posedge clk); #1;
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (!acc) waits[i]++;
      @(posedge clk); #1;
      if (acc) begin
        i++;
        if (i < n) begin
          in_data = msg[i];
          in_last = (i == n - 1);
        end
      end
      budget++;
      if (budget > 3000) begin
        timed_out = 1;
        break;
      end
    end
    if (i != abort_at) begin
      in_valid = 0; in_last = 0; out_ready = 1;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [255:0] rfc_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i+:32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    return k;
  endfunction

  task automatic test_reset;
    logic [31:0] got [10];
    logic [31:0] expv [10];
    repeat (3) @(posedge clk);
    #1;
    got = '{32'(out_valid), 32'(in_ready), 32'(blk_start), 32'(busy), 32'(ctr_wrap),
            out_data, 32'(out_last), blk_state_in[12], blk_state_in[4], blk_state_in[0]};
    expv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h61707865};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== expv[i]) begin
        failures++;
        $display("FAIL reset item=%0d got=%h exp=%h", i, got[i], expv[i]);
      end
    end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_rfc;
    int b;
    b = got_d.size();
    msg[0] = 0;
    do_load(rfc_key(), {32'h0, 32'h4a000000, 32'h09000000}, 32'd1);
    run_msg(1, 0, -1, -1);
    checks++;
    if (timed_out || got_d.size() != b + 1) begin
      failures++;
      $display("FAIL rfc_count got=%0d exp=1 timeout=%0b", got_d.size() - b, timed_out);
    end else begin
      checks++;
      if (got_d[b] !== 32'he4e7f110 || got_l[b] !== 1'b1) begin
        failures++;
        $display("FAIL rfc_word got=%h/%0b exp=e4e7f110/1", got_d[b], got_l[b]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rfc_idle busy got=%0b exp=0", busy);
    end
  endtask

  task automatic test_multi_block;
    logic [255:0] k;
    logic [95:0] n;
    int b, s0;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    n = {$urandom, $urandom, $urandom};
    for (int j = 0; j < 20; j++) msg[j] = $urandom;
    b = got_d.size(); s0 = start_ctr.size();
    do_load(k, n, 32'd1);
    run_msg(20, 0, -1, -1);
    checks++;
    if (timed_out || got_d.size() != b + 20) begin
      failures++;
      $display("FAIL multi_count got=%0d exp=20 timeout=%0b", got_d.size() - b, timed_out);
    end else begin
      for (int j = 0; j < 20; j++) begin
        checks++;
        if (got_d[b+j] !== (msg[j] ^ exp_ks(k, n, 32'd1, j)) || got_l[b+j] !== (j == 19)) begin
          failures++;
          $display("FAIL multi word=%0d got=%h/%0b exp=%h/%0b", j, got_d[b+j], got_l[b+j],
                   msg[j] ^ exp_ks(k, n, 32'd1, j), j == 19);
        end
      end
      checks++;
      if (start_ctr.size() != s0 + (PF ? 3 : 2)) begin
        failures++;
        $display("FAIL multi_starts got=%0d exp=%0d", start_ctr.size() - s0, PF ? 3 : 2);
      end else begin
        checks++;
        if (start_ctr[s0+1] !== 32'd2 || !(start_cyc[s0+1] < got_cyc[b+16])) begin
          failures++;
          $display("FAIL multi_second_start ctr got=%0d exp=2 start_cyc=%0d word16_cyc=%0d",
                   start_ctr[s0+1], start_cyc[s0+1], got_cyc[b+16]);
        end
      end
    end
    checks++;
    if (waits[0] != 2 + WAIT_MIN) begin
      failures++;
      $display("FAIL multi_first_stall got=%0d exp=%0d", waits[0], 2 + WAIT_MIN);
    end
    checks++;
    if (waits[16] != (PF ? 0 : 2 + WAIT_MIN)) begin
      failures++;
      $display("FAIL multi_boundary_stall got=%0d exp=%0d", waits[16], PF ? 0 : 2 + WAIT_MIN);
    end
  endtask

  task automatic test_backpressure;
    logic [255:0] k;
    logic [95:0] n;
    logic [31:0] c;
    int b;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    n = {$urandom, $urandom, $urandom};
    c = $urandom;
    for (int j = 0; j < 16; j++) msg[j] = $urandom;
    b = got_d.size();
    do_load(k, n, c);
    run_msg(16, 1, 5, -1);
    checks++;
    if (!held || hold_bad || hold_inrdy) begin
      failures++;
      $display("FAIL backpressure_hold held=%0b unstable=%0b in_ready_seen=%0b exp=1/0/0",
               held, hold_bad, hold_inrdy);
    end
    checks++;
    if (timed_out || got_d.size() != b + 16) begin
      failures++;
      $display("FAIL backpressure_count got=%0d exp=16 timeout=%0b", got_d.size() - b, timed_out);
    end else
      for (int j = 0; j < 16; j++) begin
        checks++;
        if (got_d[b+j] !== (msg[j] ^ exp_ks(k, n, c, j)) || got_l[b+j] !== (j == 15)) begin
          failures++;
          $display("FAIL backpressure word=%0d got=%h/%0b exp=%h/%0b", j, got_d[b+j], got_l[b+j],
                   msg[j] ^ exp_ks(k, n, c, j), j == 15);
        end
      end
  endtask

  task automatic test_wrap;
    logic [255:0] k;
    logic [95:0] n;
    int b, s0;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    n = {$urandom, $urandom, $urandom};
    for (int j = 0; j < 17; j++) msg[j] = $urandom;
    b = got_d.size(); s0 = start_ctr.size();
    do_load(k, n, 32'hffffffff);
    run_msg(17, 1, -1, -1);
    checks++;
    if (timed_out || got_d.size() != b + 17 || start_ctr.size() < s0 + 2) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=17 timeout=%0b", got_d.size() - b, timed_out);
    end else begin
      for (int j = 0; j < 17; j++) begin
        checks++;
        if (got_d[b+j] !== (msg[j] ^ exp_ks(k, n, 32'hffffffff, j))) begin
          failures++;
          $display("FAIL wrap word=%0d got=%h exp=%h", j, got_d[b+j],
                   msg[j] ^ exp_ks(k, n, 32'hffffffff, j));
        end
      end
      checks++;
      if (start_ctr[s0+1] !== 32'd0) begin
        failures++;
        $display("FAIL wrap_second_ctr got=%h exp=0", start_ctr[s0+1]);
      end
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (ctr_wrap !== 1'b1) begin
      failures++;
      $display("FAIL wrap_sticky got=%0b exp=1", ctr_wrap);
    end
    msg[0] = $urandom;
    do_load(k, n, 32'd5);
    checks++;
    if (ctr_wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_clear_on_load got=%0b exp=0", ctr_wrap);
    end
    run_msg(1, 0, -1, -1);
  endtask

  task automatic test_reset_mid;
    int b;
    for (int j = 0; j < 20; j++) msg[j] = $urandom;
    b = got_d.size();
    do_load({8{$urandom}}, {3{$urandom}}, $urandom);
    run_msg(20, 0, -1, 7);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({out_valid, in_ready, blk_start, busy} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=0000", {out_valid, in_ready, blk_start, busy});
    end
    in_valid = 0; in_last = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    checks++;
    if (got_d.size() != b + 6) begin
      failures++;
      $display("FAIL reset_mid_words got=%0d exp=6", got_d.size() - b);
    end
    b = got_d.size();
    msg[0] = 0;
    do_load(rfc_key(), {32'h0, 32'h4a000000, 32'h09000000}, 32'd1);
    run_msg(1, 0, -1, -1);
    checks++;
    if (got_d.size() != b + 1 || got_d[b] !== 32'he4e7f110) begin
      failures++;
      $display("FAIL reset_mid_reload got=%h count=%0d exp=e4e7f110/1",
               got_d.size() > b ? got_d[b] : 32'h0, got_d.size() - b);
    end
  endtask

  task automatic test_early_done;
    logic [255:0] k;
    logic [95:0] n;
    logic [31:0] c;
    int b;
    early = 1;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    n = {$urandom, $urandom, $urandom};
    c = $urandom;
    for (int j = 0; j < 20; j++) msg[j] = $urandom;
    b = got_d.size();
    do_load(k, n, c);
    run_msg(20, 0, -1, -1);
    checks++;
    if (timed_out || got_d.size() != b + 20) begin
      failures++;
      $display("FAIL early_count got=%0d exp=20 timeout=%0b", got_d.size() - b, timed_out);
    end else
      for (int j = 0; j < 20; j++) begin
        checks++;
        if (got_d[b+j] !== (msg[j] ^ exp_ks(k, n, c, j))) begin
          failures++;
          $display("FAIL early word=%0d got=%h exp=%h", j, got_d[b+j], msg[j] ^ exp_ks(k, n, c, j));
        end
      end
    checks++;
    if (waits[0] != 2 + WAIT_MIN || waits[16] != (PF ? 0 : 2 + WAIT_MIN)) begin
      failures++;
      $display("FAIL early_capture_time stall0=%0d stall16=%0d exp=%0d/%0d", waits[0], waits[16],
               2 + WAIT_MIN, PF ? 0 : 2 + WAIT_MIN);
    end
    early = 0;
  endtask

  initial begin
    test_reset;
    test_rfc;
    test_multi_block;
    test_backpressure;
    test_wrap;
    test_reset_mid;
    test_early_done;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
